// File: rtl/rv32i_types.sv
// Shared RV32I types for the datapath slice.
// Holds the load/store funct3 encodings, the memory access unit state
// encoding, and the legality check used when a request is accepted.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    idle   = 2'b00,
    access = 2'b01,
    resp   = 2'b10
  } mau_state_t;

  // Halfwords need an even address, words need a 4-byte aligned address,
  // and any funct3 outside the listed encodings is rejected.
  function automatic logic access_legal(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic legal_s;
    legal_s = 1'b0;
    if (write) begin
      case (funct3)
        sb:      legal_s = 1'b1;
        sh:      legal_s = ~offset[0];
        sw:      legal_s = (offset == 2'b00);
        default: legal_s = 1'b0;
      endcase
    end else begin
      case (funct3)
        lb, lbu: legal_s = 1'b1;
        lh, lhu: legal_s = ~offset[0];
        lw:      legal_s = (offset == 2'b00);
        default: legal_s = 1'b0;
      endcase
    end
    return legal_s;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: moves the addressed byte/halfword of a memory word down to
// bit 0 and sign- or zero-extends it according to the load funct3.
// Ports:
//   rdata  - word returned by memory
//   offset - byte offset within the word (addr[1:0])
//   funct3 - load funct3 (LB/LH/LW/LBU/LHU)
//   result - aligned, extended load data (0 for unknown funct3)
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  // Shift the addressed lane to bit 0, then extend by access size.
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    case (funct3)
      lb:      result = {{24{shifted_s[7]}}, shifted_s[7:0]};
      lh:      result = {{16{shifted_s[15]}}, shifted_s[15:0]};
      lw:      result = shifted_s;
      lbu:     result = {24'h00_0000, shifted_s[7:0]};
      lhu:     result = {16'h0000, shifted_s[15:0]};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the datapath and the data
// memory port. Accepts one request in IDLE, drives a word-aligned memory
// access until mem_resp (or a timeout), then emits a one-cycle response.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   req_valid/req_ready           - request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata   - access type, size, byte address, store data
//   mem_address/read/write        - registered memory request
//   mem_wmask/mem_wdata           - byte enables and lane-replicated store data
//   mem_rdata/mem_resp            - memory read word and completion
//   rsp_valid/rsp_rdata           - one-cycle completion and load result
//   misaligned/timeout            - error qualifiers of rsp_valid
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misaligned,
  output logic        timeout
);

  // The counter only ever holds 0..TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);

  mau_state_t       state_r;
  logic             write_r;
  logic [2:0]       funct3_r;
  logic [1:0]       offset_r;
  logic [CNT_W-1:0] wait_cnt_r;

  logic             legal_s;
  logic [3:0]       wmask_s;
  logic [31:0]      wdata_s;
  logic [31:0]      load_data_s;
  logic             terminal_s;

  assign req_ready  = (state_r == idle);
  assign legal_s    = access_legal(req_write, req_funct3, req_addr[1:0]);
  assign terminal_s = TIMEOUT_EN && (wait_cnt_r == CNT_LAST);

  // Store byte enables and lane-replicated data from the incoming request.
  always_comb begin
    case (req_funct3)
      sb: begin
        wmask_s = 4'b0001 << req_addr[1:0];
        wdata_s = {4{req_wdata[7:0]}};
      end
      sh: begin
        wmask_s = 4'b0011 << req_addr[1:0];
        wdata_s = {2{req_wdata[15:0]}};
      end
      sw: begin
        wmask_s = 4'b1111;
        wdata_s = req_wdata;
      end
      default: begin
        wmask_s = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (offset_r),
    .funct3 (funct3_r),
    .result (load_data_s)
  );

  // Access FSM with registered memory request and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= idle;
      write_r     <= 1'b0;
      funct3_r    <= 3'b000;
      offset_r    <= 2'b00;
      wait_cnt_r  <= '0;
      mem_address <= 32'h0000_0000;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wmask   <= 4'b0000;
      mem_wdata   <= 32'h0000_0000;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0000_0000;
      misaligned  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state_r)
        idle: begin
          if (req_valid) begin
            write_r  <= req_write;
            funct3_r <= req_funct3;
            offset_r <= req_addr[1:0];
            if (legal_s) begin
              mem_address <= {req_addr[31:2], 2'b00};
              mem_read    <= ~req_write;
              mem_write   <= req_write;
              mem_wmask   <= req_write ? wmask_s : 4'b0000;
              mem_wdata   <= req_write ? wdata_s : 32'h0000_0000;
              wait_cnt_r  <= '0;
              state_r     <= access;
            end else begin
              // Illegal requests never touch memory.
              rsp_valid  <= 1'b1;
              rsp_rdata  <= 32'h0000_0000;
              misaligned <= 1'b1;
              timeout    <= 1'b0;
              state_r    <= resp;
            end
          end
        end
        access: begin
          // A response on the terminal count still completes normally.
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= write_r ? 32'h0000_0000 : load_data_s;
            state_r   <= resp;
          end else if (terminal_s) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'h0000_0000;
            timeout   <= 1'b1;
            state_r   <= resp;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        resp: begin
          rsp_valid  <= 1'b0;
          rsp_rdata  <= 32'h0000_0000;
          misaligned <= 1'b0;
          timeout    <= 1'b0;
          state_r    <= idle;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          rsp_valid <= 1'b0;
          state_r   <= idle;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access sequencer between the datapath and the data-memory port. It accepts one request per transaction from control, with the address taken from the MARMUX output and store data from rs2. It drives a word-aligned memory request with byte mask and waits for `mem_resp`. It then returns aligned, sign- or zero-extended load data to the REGFILEMUX load input, with misalignment and timeout reporting.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  control requests an access.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
- `req_addr`  in  32  byte address (MARMUX output).
- `req_wdata`  in  32  store data (rs2).
- `mem_address`  out  32  `{addr[31:2],2'b00}`.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `mem_wmask`  out  4  byte enables for stores.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read word.
- `mem_resp`  in  1  memory completion.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  aligned, extended load data; 0 for stores and errors.
- `misaligned`  out  1  qualifies `rsp_valid`.
- `timeout`  out  1  qualifies `rsp_valid`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE** on acceptance:
  - Latch write, funct3, addr and wdata.
  - Check legality: H needs `addr[0]==0`; W needs `addr[1:0]==0`; unlisted funct3 is illegal.
  - Illegal request: go to RESP with `misaligned=1`; no memory strobe is ever raised.
  - Legal request: go to ACCESS.
- **ACCESS**:
  - `mem_read` or `mem_write` is held high, with address, wmask and wdata stable.
  - On `mem_resp` sampled high: capture the extracted load data, go to RESP.
  - On the wait counter reaching `TIMEOUT_CYCLES` without `mem_resp`: go to RESP with `timeout=1`.
- **RESP**: `rsp_valid=1` for exactly one cycle, then return to IDLE.
- Store mask and data:
  - SB: mask `4'b0001<<addr[1:0]`, data `{4{wdata[7:0]}}`.
  - SH: mask `4'b0011<<addr[1:0]`, data `{2{wdata[15:0]}}`.
  - SW: mask `4'b1111`, data `wdata`.
- Load extraction:
  - Shift `mem_rdata` right by `addr[1:0]*8`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Ignored inputs:
  - `req_valid` outside IDLE.
  - `mem_resp` outside ACCESS.
  - `mem_rdata` when `mem_resp` is low.

## Timing
- All outputs are registered except `req_ready`, which is decoded from the state.
- Reset values: state IDLE; `req_ready=1` once reset is released. All other outputs are 0: `mem_*` strobes, mask, data, address, `rsp_*`, `misaligned`, `timeout`.
- Legal request accepted at edge N:
  - strobe high in cycle N+1.
  - `mem_resp` in cycle N+1+k (k≥0) gives `rsp_valid` in cycle N+2+k.
  - The strobe drops in the same cycle `rsp_valid` rises.
- Illegal request accepted at edge N: `rsp_valid` with `misaligned` in cycle N+1.
- Timeout:
  - The wait counter clears on entry to ACCESS and increments each ACCESS cycle without `mem_resp`.
  - Abort happens after `TIMEOUT_CYCLES` such cycles.
  - `mem_resp` in the same cycle as the terminal count wins: normal completion, `timeout=0`.
- Minimum turnaround: the next request is accepted in the cycle after RESP. Back-to-back throughput is one access per 3+k cycles.
- Reset asserted mid-ACCESS: strobes drop asynchronously, no `rsp_valid` is produced, the outstanding transaction is abandoned, and a later `mem_resp` is ignored.

## Structure
- Shared package (existing `rv32i_types`) holds:
  - `load_funct3_t` and `store_funct3_t` enums.
  - `mau_state_t` enum {IDLE, ACCESS, RESP}.
- Sub-module `load_align`: combinational (rdata, offset, funct3) → 32-bit extended result. It is instantiated once and unit-tested separately.
- The FSM, counter and store lane logic stay in the top module.

## Test plan
- LW addr 0x100, memory returns 0xDEADBEEF after 3 wait cycles -> `mem_address` 0x100, `mem_read` held 4 cycles, `rsp_rdata` 0xDEADBEEF, `rsp_valid` one cycle.
- LB addr 0x103, rdata 0x80_00_00_00 -> `rsp_rdata` 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102, rdata 0xBEEF_0000 -> 0x0000BEEF.
- SB addr 0x201, wdata 0x000000A5 -> `mem_address` 0x200, `mem_wmask` 4'b0010, `mem_wdata` 0xA5A5A5A5; SH addr 0x202 -> mask 4'b1100.
- LW addr 0x102 and SH addr 0x101 -> no strobe, `rsp_valid` with `misaligned=1` the next cycle, `rsp_rdata` 0.
- `TIMEOUT_CYCLES=4`, `mem_resp` never asserted -> strobe high 4 cycles, then `rsp_valid` with `timeout=1`. `mem_resp` on the 4th cycle -> normal completion, `timeout=0`.
- `rst` pulsed mid-ACCESS -> strobes low immediately, no `rsp_valid`, `req_ready=1` after release; a stray `mem_resp` afterwards is ignored.
